// File: rtl/mult_norm_stage_pkg.sv
// Shared binary32 constants, FSM states and helpers for the
// FP multiplier front end and the rounder that follows it.
package mult_norm_stage_pkg;

  localparam int BIAS     = 127;
  localparam int EXP_W    = 10;
  localparam int SIGN_BIT = 31;
  localparam int EXP_MSB  = 30;
  localparam int EXP_LSB  = 23;
  localparam int FRAC_MSB = 22;
  localparam int FRAC_W   = 23;
  localparam int SIG_W    = 24;
  localparam int PROD_W   = 48;
  localparam int CNT_W    = 5;

  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(SIG_W - 1);

  typedef enum logic [1:0] {
    IDLE,
    MULT,
    NORM,
    DONE
  } state_e;

  // Unsigned sum minus bias, wrapping in EXP_W bits.
  function automatic logic [EXP_W-1:0] exp_add(
    input logic [7:0] ea,
    input logic [7:0] eb
  );
    return EXP_W'(ea) + EXP_W'(eb) - EXP_W'(BIAS);
  endfunction

endpackage

// File: rtl/mult_norm_stage_if.sv
// Operand/result handshake bundle between the multiplier
// front end, its upstream source and the rounder.
interface mult_norm_stage_if;
  import mult_norm_stage_pkg::*;

  logic              in_valid;
  logic              in_ready;
  logic [31:0]       a;
  logic [31:0]       b;
  logic              out_valid;
  logic              out_ready;
  logic              sign;
  logic [EXP_W-1:0]  norm_exponent;
  logic [FRAC_W-1:0] norm_mantissa;
  logic              guard_bit;
  logic              sticky_bit;

  modport slave (
    input  in_valid, a, b, out_ready,
    output in_ready, out_valid, sign,
    output norm_exponent, norm_mantissa,
    output guard_bit, sticky_bit
  );

  modport master (
    output in_valid, a, b, out_ready,
    input  in_ready, out_valid, sign,
    input  norm_exponent, norm_mantissa,
    input  guard_bit, sticky_bit
  );

endinterface

// File: rtl/mult_norm_stage_mant_normalizer.sv
// Combinational normaliser: picks the leading one of the
// 48-bit product and slices mantissa, guard and sticky.
module mant_normalizer
  import mult_norm_stage_pkg::*;
(
  input  logic [PROD_W-1:0] prod_i,
  input  logic [EXP_W-1:0]  exp_i,
  output logic [FRAC_W-1:0] mant_o,
  output logic              guard_o,
  output logic              sticky_o,
  output logic [EXP_W-1:0]  exp_o
);

  always_comb begin
    mant_o   = prod_i[45:23];
    guard_o  = prod_i[22];
    sticky_o = |prod_i[21:0];
    exp_o    = exp_i;
    // Product of two [1,2) values lies in [1,4).
    if (prod_i[47]) begin
      mant_o   = prod_i[46:24];
      guard_o  = prod_i[23];
      sticky_o = |prod_i[22:0];
      exp_o    = exp_i + EXP_W'(1);
    end
  end

endmodule

// File: rtl/mult_norm_stage.sv
// Iterative shift-add significand multiplier with a
// normalise step feeding the rounder.
module mult_norm_stage
  import mult_norm_stage_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  mult_norm_stage_if.slave bus
);

  state_e              state_q, state_d;
  logic [SIG_W-1:0]    a_sig_q, a_sig_d;
  logic [SIG_W-1:0]    b_sig_q, b_sig_d;
  logic [PROD_W-1:0]   acc_q, acc_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [EXP_W-1:0]    exp_sum_q, exp_sum_d;
  logic                sign_q, sign_d;
  logic [EXP_W-1:0]    exp_q, exp_d;
  logic [FRAC_W-1:0]   mant_q, mant_d;
  logic                guard_q, guard_d;
  logic                sticky_q, sticky_d;

  logic [FRAC_W-1:0]   n_mant;
  logic                n_guard;
  logic                n_sticky;
  logic [EXP_W-1:0]    n_exp;

  mant_normalizer u_norm (
    .prod_i   (acc_q),
    .exp_i    (exp_sum_q),
    .mant_o   (n_mant),
    .guard_o  (n_guard),
    .sticky_o (n_sticky),
    .exp_o    (n_exp)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      a_sig_q   <= '0;
      b_sig_q   <= '0;
      acc_q     <= '0;
      cnt_q     <= '0;
      exp_sum_q <= '0;
      sign_q    <= 1'b0;
      exp_q     <= '0;
      mant_q    <= '0;
      guard_q   <= 1'b0;
      sticky_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      a_sig_q   <= a_sig_d;
      b_sig_q   <= b_sig_d;
      acc_q     <= acc_d;
      cnt_q     <= cnt_d;
      exp_sum_q <= exp_sum_d;
      sign_q    <= sign_d;
      exp_q     <= exp_d;
      mant_q    <= mant_d;
      guard_q   <= guard_d;
      sticky_q  <= sticky_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    a_sig_d   = a_sig_q;
    b_sig_d   = b_sig_q;
    acc_d     = acc_q;
    cnt_d     = cnt_q;
    exp_sum_d = exp_sum_q;
    sign_d    = sign_q;
    exp_d     = exp_q;
    mant_d    = mant_q;
    guard_d   = guard_q;
    sticky_d  = sticky_q;
    unique case (state_q)
      IDLE: begin
        if (bus.in_valid) begin
          a_sig_d   = {1'b1, bus.a[FRAC_MSB:0]};
          b_sig_d   = {1'b1, bus.b[FRAC_MSB:0]};
          sign_d    = bus.a[SIGN_BIT] ^ bus.b[SIGN_BIT];
          exp_sum_d = exp_add(bus.a[EXP_MSB:EXP_LSB],
                              bus.b[EXP_MSB:EXP_LSB]);
          acc_d     = '0;
          cnt_d     = '0;
          state_d   = MULT;
        end
      end
      MULT: begin
        // One multiplier bit per cycle, LSB first.
        if (b_sig_q[cnt_q]) begin
          acc_d = acc_q + (PROD_W'(a_sig_q) << cnt_q);
        end
        cnt_d = cnt_q + CNT_W'(1);
        if (cnt_q == LAST_CNT) begin
          state_d = NORM;
        end
      end
      NORM: begin
        exp_d    = n_exp;
        mant_d   = n_mant;
        guard_d  = n_guard;
        sticky_d = n_sticky;
        state_d  = DONE;
      end
      DONE: begin
        if (bus.out_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign bus.in_ready      = (state_q == IDLE);
  assign bus.out_valid     = (state_q == DONE);
  assign bus.sign          = sign_q;
  assign bus.norm_exponent = exp_q;
  assign bus.norm_mantissa = mant_q;
  assign bus.guard_bit     = guard_q;
  assign bus.sticky_bit    = sticky_q;

endmodule

// File: tb/tb_mult_norm_stage.sv
// Self-checking bench for mult_norm_stage: directed vectors,
// backpressure, mid-flight reset and randomized operands.
module tb_mult_norm_stage;
  import mult_norm_stage_pkg::*;

  typedef logic [35:0] res_t;

  logic clk = 1'b0;
  logic rst;
  int   n_checks = 0;
  int   n_err = 0;

  mult_norm_stage_if bus();

  mult_norm_stage dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  function automatic res_t model(input logic [31:0] a,
                                 input logic [31:0] b);
    logic [47:0] p;
    int          ex;
    int          sh;
    logic [22:0] m;
    logic        g;
    logic        s;
    p  = 48'({1'b1, a[22:0]}) * 48'({1'b1, b[22:0]});
    ex = int'(a[30:23]) + int'(b[30:23]) - 127;
    sh = 23;
    if (p >= (48'd1 << 47)) begin
      sh = 24;
      ex = ex + 1;
    end
    m = 23'(p >> sh);
    g = 1'(p >> (sh - 1));
    s = (p % (48'd1 << (sh - 1))) != 48'd0;
    return {a[31] ^ b[31], 10'(ex), m, g, s};
  endfunction

  function automatic res_t observed();
    return {bus.sign, bus.norm_exponent, bus.norm_mantissa,
            bus.guard_bit, bus.sticky_bit};
  endfunction

  task automatic run_op(input logic [31:0] a,
                        input logic [31:0] b,
                        input res_t        exp_r,
                        input int          hold,
                        input string       name);
    int lat;
    @(negedge clk);
    bus.a = a;
    bus.b = b;
    bus.in_valid = 1'b1;
    n_checks++;
    if (bus.in_ready !== 1'b1) begin
      n_err++;
      $display("FAIL %s_accept in_ready=%b want 1",
               name, bus.in_ready);
    end
    @(negedge clk);
    bus.in_valid = 1'b0;
    bus.a = $urandom;
    bus.b = $urandom;
    lat = 0;
    while (bus.out_valid !== 1'b1 && lat < 40) begin
      if (lat == 5) bus.in_valid = 1'b1;
      if (lat == 8) bus.in_valid = 1'b0;
      @(negedge clk);
      lat++;
    end
    bus.in_valid = 1'b0;
    n_checks++;
    if (lat !== 25) begin
      n_err++;
      $display("FAIL %s_latency got=%0d want 25", name, lat);
    end
    n_checks++;
    if (bus.in_ready !== 1'b0) begin
      n_err++;
      $display("FAIL %s_ready_excl in_ready=%b want 0",
               name, bus.in_ready);
    end
    n_checks++;
    if (observed() !== exp_r) begin
      n_err++;
      $display("FAIL %s_result got=%h want %h",
               name, observed(), exp_r);
    end
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      n_checks++;
      if ({bus.out_valid, bus.in_ready, observed()} !==
          {1'b1, 1'b0, exp_r}) begin
        n_err++;
        $display("FAIL %s_hold%0d got=%b%b_%h want 10_%h",
                 name, i, bus.out_valid, bus.in_ready,
                 observed(), exp_r);
      end
    end
    bus.out_ready = 1'b1;
    @(negedge clk);
    bus.out_ready = 1'b0;
    n_checks++;
    if ({bus.out_valid, bus.in_ready} !== 2'b01) begin
      n_err++;
      $display("FAIL %s_release valid/ready=%b%b want 01",
               name, bus.out_valid, bus.in_ready);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    bus.in_valid = 1'b0;
    bus.out_ready = 1'b0;
    bus.a = '0;
    bus.b = '0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    n_checks++;
    if ({bus.in_ready, bus.out_valid, observed()} !==
        {1'b1, 1'b0, 36'h0}) begin
      n_err++;
      $display("FAIL reset got=%b%b_%h want 10_0",
               bus.in_ready, bus.out_valid, observed());
    end
  endtask

  task automatic test_directed();
    run_op(32'h3F800000, 32'h3F800000,
           {1'b0, 10'd127, 23'h000000, 1'b0, 1'b0}, 0, "one");
    run_op(32'h3FC00000, 32'h3FC00000,
           {1'b0, 10'd128, 23'h100000, 1'b0, 1'b0}, 1, "sq15");
    run_op(32'h3F800001, 32'h3FC00000,
           {1'b0, 10'd127, 23'h400001, 1'b1, 1'b0}, 0, "guard");
    run_op(32'h3F800001, 32'h3F800001,
           {1'b0, 10'd127, 23'h000002, 1'b0, 1'b1}, 0, "sticky");
  endtask

  task automatic test_backpressure();
    run_op(32'hC0000000, 32'h40400000,
           {1'b1, 10'd129, 23'h400000, 1'b0, 1'b0}, 10, "bp");
  endtask

  task automatic test_exp_wrap();
    run_op(32'h7F000000, 32'h7F000000,
           {1'b0, 10'h17D, 23'h0, 1'b0, 1'b0}, 0, "exp_hi");
  endtask

  task automatic test_reset_midflight();
    int seen;
    @(negedge clk);
    bus.a = 32'h3FC00000;
    bus.b = 32'h3FC00000;
    bus.in_valid = 1'b1;
    @(negedge clk);
    bus.in_valid = 1'b0;
    repeat (10) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    n_checks++;
    if ({bus.in_ready, bus.out_valid, observed()} !==
        {1'b1, 1'b0, 36'h0}) begin
      n_err++;
      $display("FAIL midrst got=%b%b_%h want 10_0",
               bus.in_ready, bus.out_valid, observed());
    end
    seen = 0;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      if (bus.out_valid === 1'b1) seen++;
    end
    n_checks++;
    if (seen !== 0) begin
      n_err++;
      $display("FAIL midrst_stale out_valid_cycles=%0d want 0",
               seen);
    end
    run_op(32'h00800000, 32'h00800000,
           {1'b0, 10'h383, 23'h0, 1'b0, 1'b0}, 0, "exp_lo");
  endtask

  task automatic test_random();
    logic [31:0] a;
    logic [31:0] b;
    for (int i = 0; i < 20; i++) begin
      a = $urandom;
      b = $urandom;
      if (i == 0) begin
        a = 32'h3FFFFFFF;
        b = 32'hBFFFFFFF;
      end
      run_op(a, b, model(a, b), int'($urandom_range(0, 3)),
             $sformatf("rnd%0d", i));
    end
  endtask

  task automatic test_back_to_back();
    run_op(32'h40490FDB, 32'h402DF854,
           model(32'h40490FDB, 32'h402DF854), 0, "b2b0");
    run_op(32'hC1200000, 32'h3DCCCCCD,
           model(32'hC1200000, 32'h3DCCCCCD), 0, "b2b1");
  endtask

  initial begin
    test_reset();
    test_directed();
    test_backpressure();
    test_exp_wrap();
    test_reset_midflight();
    test_random();
    test_back_to_back();
    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
